fetch_pc_unit: RTL

Instruction-fetch PC generator that sits directly upstream of the two-bit branch predictor.
- Holds the fetch PC and presents the fetched instruction to the predictor.
- Consumes the predictor's takebr/takej outputs to pick the next PC.
- Tracks every in-flight branch prediction in a small queue and checks it against the EX-stage outcome. On a mismatch or a JR/JALR it redirects fetch and flushes.
- Drives the predictor's istaken input with the resolved outcome.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/pred_queue.sv | 78 +++++++
 rtl/fetch_pc_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch PC unit: opcodes, fetch state and the
// prediction-queue entry layout.
package mips_pkg;

    localparam logic [5:0] OP_BZ   = 6'd1;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        pred;
        logic [31:0] alt;
    } pred_entry_t;

    // Conditional-branch opcodes tracked by the prediction queue
    function automatic logic is_branch(input logic [5:0] op);
        logic res;
        case (op)
            OP_BZ, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: res = 1'b1;
            default:                                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pred_queue.sv
// FIFO of in-flight branch predictions. Clear beats push; a push into a full
// queue is accepted only when a pop happens in the same cycle.
module pred_queue
    import mips_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    input  logic        clear,
    output logic        full,
    output logic        empty,
    output pred_entry_t head
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    pred_entry_t      mem_r [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(QDEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Qualify requests against occupancy
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer, count and storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: next-PC selection, branch prediction tracking and
// redirect on mispredict or JR/JALR. Define FETCH_STATS_EN for branch counters.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic        takebr,
    input  logic        takej,
    input  logic        ex_br_valid,
    input  logic        ex_br_taken,
    input  logic        ex_jr_valid,
    input  logic [31:0] ex_jr_target,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        flush,
    output logic        istaken,
    output logic        q_full,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        underflow_err
);

    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    logic         underflow_r;

    logic         isbr_s;
    logic [31:0]  pc4_s;
    logic [31:0]  btgt_s;
    logic [31:0]  jtgt_s;
    logic         run_s;

    logic         q_full_s;
    logic         q_empty_s;
    pred_entry_t  q_head_s;
    pred_entry_t  push_data_s;
    logic         push_s;
    logic         pop_ok_s;
    logic         mispredict_s;
    logic         redirect_s;
    logic [31:0]  redirect_pc_s;
    logic         hold_s;

    assign isbr_s = is_branch(instr[31:26]);
    assign pc4_s  = pc_r + 32'd4;
    assign btgt_s = pc4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jtgt_s = {pc4_s[31:28], instr[25:0], 2'b00};
    assign run_s  = (state_r == ST_RUN);

    assign pop_ok_s      = ex_br_valid && !q_empty_s;
    assign mispredict_s  = pop_ok_s && (ex_br_taken != q_head_s.pred);
    assign redirect_s    = mispredict_s || ex_jr_valid;
    assign redirect_pc_s = mispredict_s ? q_head_s.alt : ex_jr_target;
    // A pop frees the slot this cycle, so a full queue need not hold fetch
    assign hold_s        = isbr_s && run_s && q_full_s && !pop_ok_s;
    assign push_s        = isbr_s && run_s && !stall && !redirect_s && !hold_s;
    assign push_data_s   = '{pred: takebr, alt: (takebr ? pc4_s : btgt_s)};

    pred_queue #(
        .QDEPTH(QDEPTH)
    ) u_pred_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .push_data(push_data_s),
        .pop      (ex_br_valid),
        .clear    (redirect_s),
        .full     (q_full_s),
        .empty    (q_empty_s),
        .head     (q_head_s)
    );

    // Next-PC and state selection: redirect > stall > full hold > normal
    always_comb begin
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        if (redirect_s) begin
            pc_nxt_s    = redirect_pc_s;
            state_nxt_s = ST_BUBBLE;
        end else if (stall) begin
            pc_nxt_s    = pc_r;
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_BUBBLE: begin
                    pc_nxt_s    = pc4_s;
                    state_nxt_s = ST_RUN;
                end
                ST_RUN: begin
                    state_nxt_s = ST_RUN;
                    if (hold_s) begin
                        pc_nxt_s = pc_r;
                    end else if (takej) begin
                        pc_nxt_s = jtgt_s;
                    end else if (isbr_s && takebr) begin
                        pc_nxt_s = btgt_s;
                    end else begin
                        pc_nxt_s = pc4_s;
                    end
                end
                default: begin
                    pc_nxt_s    = pc4_s;
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // PC, fetch state and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            state_r     <= ST_RUN;
            underflow_r <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            state_r <= state_nxt_s;
            if (ex_br_valid && q_empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating resolution counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (pop_ok_s && (stat_branches_r != 32'hFFFF_FFFF)) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

    assign pc            = pc_r;
    assign if_valid      = run_s && !rst;
    assign flush         = redirect_s && !rst;
    assign istaken       = ex_br_valid && ex_br_taken && !rst;
    assign q_full        = q_full_s && !rst;
    assign underflow_err = underflow_r;

endmodule
